// File: rtl/rom_burst_reader_if.sv
// ROM access bus plus the valid/ready word stream produced by rom_burst_reader.
// The master side is the burst reader; the slave side is the ROM together with the consumer.
interface rom_burst_reader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] rom_address;
    logic              rom_ce;
    logic              rom_read_en;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output rom_address,
        output rom_ce,
        output rom_read_en,
        input  rom_data,
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  rom_address,
        input  rom_ce,
        input  rom_read_en,
        output rom_data,
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/rom_burst_reader.sv
// Burst sequencer for a ROM: reads a contiguous run of words starting at start_addr
// and streams them out one at a time on a valid/ready interface with a last flag.
module rom_burst_reader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    rom_burst_reader_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] WAIT_RELOAD = 3'(RD_LAT - 1);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic [2:0]        wait_cnt;
    logic              rom_ce_q;
    logic              rom_rd_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              out_last_q;

    // The address register doubles as the ROM address, so it holds outside READ.
    assign bus.rom_address = addr;
    assign bus.rom_ce      = rom_ce_q;
    assign bus.rom_read_en = rom_rd_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_last    = out_last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr        <= '0;
            remaining   <= '0;
            wait_cnt    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rom_ce_q    <= 1'b0;
            rom_rd_q    <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (abort && state != IDLE) begin
            // Cancel drops any pending word, including one handshaken this cycle.
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            rom_ce_q    <= 1'b0;
            rom_rd_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && length != '0) begin
                        addr      <= start_addr;
                        remaining <= length;
                        wait_cnt  <= WAIT_RELOAD;
                        busy      <= 1'b1;
                        rom_ce_q  <= 1'b1;
                        rom_rd_q  <= 1'b1;
                        state     <= READ;
                    end
                end
                READ: begin
                    if (wait_cnt == 3'd0) begin
                        out_data_q  <= bus.rom_data;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (remaining == (ADDR_W+1)'(1));
                        rom_ce_q    <= 1'b0;
                        rom_rd_q    <= 1'b0;
                        state       <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (remaining == (ADDR_W+1)'(1)) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            // Address wraps naturally at the top of the ROM.
                            addr      <= addr + ADDR_W'(1);
                            remaining <= remaining - (ADDR_W+1)'(1);
                            wait_cnt  <= WAIT_RELOAD;
                            rom_ce_q  <= 1'b1;
                            rom_rd_q  <= 1'b1;
                            state     <= READ;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed bench for rom_burst_reader against a ROM holding mem[i] = i ^ 8'h5A.
// Burst vectors come from a table; reset, zero-length start and abort are hand sequences.
module tb_rom_burst_reader;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 1;

    typedef struct {
        logic [7:0] saddr;
        logic [8:0] len;
        int         stall;
        bit         restart;
        logic [7:0] exp_first;
        logic [7:0] exp_last;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [ADDR_W:0]   length = '0;
    logic              abort = 1'b0;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    rom_burst_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rom_burst_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    // Single-cycle ROM: data for the presented address is captured at the end of the cycle.
    assign bus.rom_data = mem[bus.rom_address];

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rom_ce"}, bus.rom_ce, 0);
        check({tag, "_rom_read_en"}, bus.rom_read_en, 0);
        check({tag, "_rom_address"}, bus.rom_address, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_data"}, bus.out_data, 0);
        check({tag, "_out_last"}, bus.out_last, 0);
    endtask

    task automatic run_burst(input vec_t v);
        int         idx = 0;
        int         stall_left = 0;
        int         cyc;
        int         budget;
        bit         prev_valid = 0;
        bit         expect_done = 0;
        bit         seen_done = 0;
        logic [7:0] held = '0;
        logic [7:0] exp_addr;
        budget = int'(v.len) * (v.stall + 3) + 20;
        @(negedge clk);
        start_addr    = v.saddr;
        length        = v.len;
        start         = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (cyc < budget && !seen_done) begin
            start    = 1'b0;
            exp_addr = v.saddr + 8'(idx);
            if (expect_done) begin
                check("done_after_last", done, 1);
                seen_done = 1;
                // A start presented in the DONE cycle must be ignored.
                if (v.restart) begin
                    start_addr = 8'h40;
                    length     = 9'd2;
                    start      = 1'b1;
                end
            end else begin
                if (done) check("done_early", done, 0);
                if (bus.rom_ce) check("rom_address", bus.rom_address, exp_addr);
                if (bus.out_valid) begin
                    check("rom_ce_in_hold", bus.rom_ce, 0);
                    if (!prev_valid) begin
                        stall_left = v.stall;
                        held       = bus.out_data;
                        if (idx == 0) check("first_valid_latency", cyc, RD_LAT + 1);
                        if (v.restart && idx == 1) begin
                            start_addr = 8'h40;
                            length     = 9'd2;
                            start      = 1'b1;
                        end
                    end else begin
                        check("hold_data_stable", bus.out_data, held);
                    end
                    if (stall_left > 0) begin
                        bus.out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        bus.out_ready = 1'b1;
                        check("word_data", bus.out_data, exp_addr ^ 8'h5A);
                        check("out_last", bus.out_last, (idx == int'(v.len) - 1));
                        if (idx == 0) check("first_word", bus.out_data, v.exp_first);
                        if (idx == int'(v.len) - 1) begin
                            check("last_word", bus.out_data, v.exp_last);
                            expect_done = 1;
                        end
                        idx++;
                    end
                end else begin
                    check("last_without_valid", bus.out_last, 0);
                end
                prev_valid = bus.out_valid;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("burst_completed", seen_done, 1);
        check("word_count", idx, v.len);
        check("idle_after_burst", busy, 0);
        check("done_single_pulse", done, 0);
    endtask

    vec_t vecs [6];

    initial begin
        int words_seen;
        bit found;

        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        vecs[0] = '{8'h05, 9'd3,   0, 1'b0, 8'h5F, 8'h5D};
        vecs[1] = '{8'hFE, 9'd4,   0, 1'b0, 8'hA4, 8'h5B};
        vecs[2] = '{8'h10, 9'd2,   5, 1'b0, 8'h4A, 8'h4B};
        vecs[3] = '{8'h20, 9'd3,   0, 1'b1, 8'h7A, 8'h78};
        vecs[4] = '{8'h00, 9'd256, 0, 1'b0, 8'h5A, 8'hA5};
        vecs[5] = '{8'h80, 9'd1,   0, 1'b0, 8'hDA, 8'hDA};
        bus.out_ready = 1'b0;

        #3;
        check_all_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset while the first word is being read.
        @(negedge clk);
        start_addr = 8'h05;
        length     = 9'd3;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mid_read_rom_ce", bus.rom_ce, 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_reset_busy", busy, 0);
            check("post_reset_rom_ce", bus.rom_ce, 0);
            check("post_reset_valid", bus.out_valid, 0);
        end

        // Zero-length request is ignored.
        start_addr = 8'h33;
        length     = 9'd0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("len0_busy", busy, 0);
            check("len0_done", done, 0);
            check("len0_rom_ce", bus.rom_ce, 0);
            @(negedge clk);
        end

        for (int i = 0; i < 6; i++) run_burst(vecs[i]);

        // Abort while word 2 of an 8-word burst is offered, with a same-cycle handshake.
        @(negedge clk);
        start_addr    = 8'h30;
        length        = 9'd8;
        start         = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        words_seen = 0;
        found      = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.out_valid) begin
                if (words_seen == 1) begin
                    check("abort_word2_data", bus.out_data, 8'h31 ^ 8'h5A);
                    abort = 1'b1;
                    found = 1;
                end
                words_seen++;
            end
            if (!found) @(negedge clk);
        end
        check("abort_reached_word2", found, 1);
        @(negedge clk);
        abort = 1'b0;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_rom_ce", bus.rom_ce, 0);
        check("abort_rom_read_en", bus.rom_read_en, 0);
        check("abort_done", done, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
            check("abort_stays_idle", busy, 0);
            check("abort_no_valid", bus.out_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
